// File: rtl/sar_result_collector.sv
// Rebuilds MSB-first SAR conversion words from the SAR_LOGIC bit stream and
// buffers them in a small FIFO behind a valid/ready port.
module sar_result_collector #(
  parameter int unsigned BITS  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     XRST,
  input  logic                     EN,
  input  logic                     CLR,
  input  logic                     DOUT_BIT,
  input  logic                     COMP_CLK,
  input  logic [BITS:0]            SDAC_IN,
  output logic [BITS-1:0]          DOUT,
  output logic                     DOUT_VALID,
  input  logic                     DOUT_READY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVF,
  output logic                     FRAME_ERR,
  output logic [15:0]              CONV_CNT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = $clog2(BITS);
  localparam logic [IW-1:0] IDX_TOP  = IW'(BITS - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [BITS:0] SDAC_MSB = {1'b1, {BITS{1'b0}}};

  typedef enum logic {HUNT, SYNC} sync_t;

  sync_t                state, state_nxt;
  logic                 cc_d;
  logic [IW-1:0]        idx;
  logic [BITS-1:1]      shreg;
  logic [AW:0]          wptr, rptr;
  logic [BITS-1:0]      mem [DEPTH];

  logic                 rise, fall, frame_start, frame_err_set;
  logic                 capture, push, pop, push_ok, full, empty;
  logic [AW:0]          level;
  logic [BITS-1:0]      push_word;

  always_comb begin
    rise          = COMP_CLK & ~cc_d;
    fall          = ~COMP_CLK & cc_d;
    frame_start   = EN & rise & (SDAC_IN == SDAC_MSB);
    frame_err_set = frame_start & (state == SYNC) & (idx != IDX_TOP);
    capture       = EN & fall & (state == SYNC);
    push          = capture & (idx == '0);
    push_word     = {shreg, DOUT_BIT};
    level         = wptr - rptr;
    full          = (level == FULL_LVL);
    empty         = (wptr == rptr);
    pop           = DOUT_READY & ~empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push_ok       = push & (~full | pop);
  end

  always_comb begin
    state_nxt = state;
    if (CLR || !EN)
      state_nxt = HUNT;
    else if (frame_start)
      state_nxt = SYNC;
  end

  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST)
      state <= HUNT;
    else
      state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      cc_d      <= 1'b0;
      idx       <= IDX_TOP;
      shreg     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      mem       <= '{default: '0};
      OVF       <= 1'b0;
      FRAME_ERR <= 1'b0;
      CONV_CNT  <= '0;
    end else begin
      cc_d <= COMP_CLK;
      if (CLR) begin
        idx       <= IDX_TOP;
        wptr      <= '0;
        rptr      <= '0;
        OVF       <= 1'b0;
        FRAME_ERR <= 1'b0;
      end else begin
        if (!EN || frame_start) begin
          idx <= IDX_TOP;
        end else if (capture) begin
          if (idx != '0) begin
            shreg[idx] <= DOUT_BIT;
            idx        <= idx - 1'b1;
          end else begin
            idx <= IDX_TOP;
          end
        end
        if (frame_err_set)
          FRAME_ERR <= 1'b1;
        if (pop)
          rptr <= rptr + 1'b1;
        if (push_ok) begin
          mem[wptr[AW-1:0]] <= push_word;
          wptr              <= wptr + 1'b1;
          CONV_CNT          <= CONV_CNT + 16'd1;
        end else if (push) begin
          OVF <= 1'b1;
        end
      end
    end
  end

  assign DOUT       = mem[rptr[AW-1:0]];
  assign DOUT_VALID = ~empty;
  assign LEVEL      = level;

endmodule
